// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder used as the per-bit step of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic carry,
  output logic sum
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, through a single full adder.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             fa_carry, fa_sum;
  logic             last_bit;

  full_adder u_full_adder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c     (carry_q),
    .carry (fa_carry),
    .sum   (fa_sum)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB is carry_q on the last step; XOR with carry out gives signed overflow.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= carry_q ^ fa_carry;
    end
  end
  assign ovf = ovf_q;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8; honours SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]);
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input bit stray);
    exp_t e;
    int   busy_cnt;
    int   lat;
    int   d0;
    e  = model(ta, tb, tc);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk);
    sb.push_back(e);
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    busy_cnt = 0;
    lat      = 0;
    for (int k = 1; k <= 3 * W && lat == 0; k++) begin
      if (busy) busy_cnt++;
      if (stray && k == 3) begin
        start = 1'b1; a = 8'h11; b = 8'h22;
      end
      if (stray && k == 4) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    check("latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("busy_in_done", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done), 32'(0));
    check("busy_after_done", 32'(busy), 32'(0));
    check("sum_held", 32'(sum), 32'(e.sum));
    @(posedge clk);
    #2;
    check("done_pulses", 32'(done_cnt - d0), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'(0));
`endif
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b1);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);

    // Abort an operation mid-flight; the scoreboard stays empty so any done is flagged.
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sum", 32'(sum), 32'(0));
    check("abort_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", 32'(ovf), 32'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #2;
    check("abort_no_done", 32'(sb.size()), 32'(0));

    do_op(8'h03, 8'h04, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH, operand A, sampled with start.
REQ-006 SHALL have port b, input, WIDTH, operand B, sampled with start.
REQ-007 SHALL have port cin, input, 1, carry-in, sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an addition is in progress (RUN state).
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, WIDTH, the result, held stable from done until the next accepted start.
REQ-011 SHALL have port cout, output, 1, the carry-out of the MSB, held with sum.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL load a and b into shift registers, set carry_q=cin, clear the bit counter, and enter RUN.
REQ-014 In RUN, each edge SHALL add one bit, LSB first:
- operands: a_sh[0], b_sh[0], carry_q
- sum bit: shifted in at the MSB of the sum shift register
- carry_q: updated to the bit carry
- counter: incremented
REQ-015 RUN SHALL last exactly WIDTH edges; the edge with counter==WIDTH-1 SHALL move to DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, sum/cout SHALL be final, and the next edge SHALL return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high between edge WIDTH and edge WIDTH+1.
REQ-018 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-019 start SHALL be ignored in RUN and DONE; operands and result SHALL be unaffected.
REQ-020 sum SHALL equal (a+b+cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of a+b+cin; wrap-around is not an error.
REQ-021 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-022 With rst_n=0, the block SHALL immediately enter IDLE, whether idle or mid-operation, with these values:
- outputs: sum=0, cout=0, busy=0, done=0
- internal state: counter=0, carry_q=0, shift registers=0
REQ-023 After rst_n rises, the first edge with start=1 SHALL be accepted normally; an aborted operation SHALL NOT produce done.

Configuration
REQ-024 With SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit), the signed overflow flag:
- value: carry into MSB XOR cout, captured on the final RUN edge
- timing: held with sum, reset to 0
REQ-025 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package serial_adder_pkg SHALL hold:
- the state typedef (IDLE, RUN, DONE)
- the default WIDTH constant
REQ-027 The per-bit addition SHALL be one instance of the existing full_adder sub-module, with port order (a, b, c, carry, sum).
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide; there SHALL be no other arithmetic in the datapath.

Verification (WIDTH=8)
REQ-029 Zero operands: a=00, b=00, cin=0 -> sum=00, cout=0, ovf=0; done high between edge 8 and edge 9; busy high for 8 cycles.
REQ-030 Unsigned wrap: a=FF, b=01, cin=0 -> sum=00, cout=1, ovf=0.
REQ-031 Signed overflow: a=7F, b=01, cin=0 -> sum=80, cout=0, ovf=1 (ovf only when SERIAL_ADDER_OVF_EN is defined).
REQ-032 Carry-in through every bit: a=A5, b=5A, cin=1 -> sum=00, cout=1.
REQ-033 Start ignored while busy: second start with a=11, b=22 at edge 3 of an A5+5A operation -> result still 00/1, with exactly one done pulse.
REQ-034 Reset mid-operation: rst_n=0 at edge 4 of RUN -> busy=0 and sum=00 immediately with no done; then a=03, b=04 -> sum=07, cout=0.
